// File: rtl/idx_collect_ctrl_if.sv
// Flag-beat and result handshake bundle for idx_collect_ctrl.
// slave = controller side, master = the upstream/downstream environment side.
interface idx_collect_ctrl_if #(
  parameter int SEG_W = 8,
  parameter int IDX_W = 6
);
  logic             i_start;
  logic             i_flag_valid;
  logic             o_flag_ready;
  logic [SEG_W-1:0] i_flags;
  logic             o_busy;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [IDX_W-1:0] o_idx1;
  logic [IDX_W-1:0] o_idx2;
  logic [IDX_W-1:0] o_idx3;
  logic [IDX_W-1:0] o_idx4;
  logic [2:0]       o_num;
  logic             o_overflow;

  modport slave (
    input  i_start, i_flag_valid, i_flags, i_res_ready,
    output o_flag_ready, o_busy, o_res_valid,
    output o_idx1, o_idx2, o_idx3, o_idx4, o_num, o_overflow
  );

  modport master (
    output i_start, i_flag_valid, i_flags, i_res_ready,
    input  o_flag_ready, o_busy, o_res_valid,
    input  o_idx1, o_idx2, o_idx3, o_idx4, o_num, o_overflow
  );
endinterface

// File: rtl/idx_collect_ctrl.sv
// Collects the first four set-bit positions of a NUM_SEG-beat flag frame into a held result list.
// Optional macro IDX_COLLECT_EARLY_DONE_EN: finish the frame as soon as four indices are held.
module idx_collect_ctrl #(
  parameter int SEG_W   = 8,
  parameter int NUM_SEG = 8,
  parameter int IDX_W   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  idx_collect_ctrl_if.slave  bus
);
  localparam int SB_W  = $clog2(SEG_W);
  localparam int BC_W  = $clog2(NUM_SEG);
  localparam int CNT_W = $clog2(SEG_W + 5) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state, state_nxt;
  logic [BC_W-1:0]  beat_cnt;
  logic [IDX_W-1:0] idx_q   [4];
  logic [IDX_W-1:0] idx_nxt [4];
  logic [2:0]       num_q, num_nxt;
  logic             ovf_q, ovf_nxt;
  logic [CNT_W-1:0] pop, sum;
  logic [2:0]       slot;
  logic             accept, last_beat, clr, full;

  assign accept    = (state == COLLECT) && bus.i_flag_valid;
  assign last_beat = (beat_cnt == BC_W'(NUM_SEG - 1));
  assign clr       = (state == IDLE) && bus.i_start;

  always_comb begin
    pop = '0;
    for (int b = 0; b < SEG_W; b++) pop = pop + CNT_W'(bus.i_flags[b]);
  end

  assign sum  = CNT_W'(num_q) + pop;
  assign full = (sum >= CNT_W'(4));

  // Append new indices after the entries already held; slots past 4 are dropped
  always_comb begin
    for (int j = 0; j < 4; j++) idx_nxt[j] = idx_q[j];
    slot = num_q;
    for (int b = 0; b < SEG_W; b++) begin
      if (bus.i_flags[b] && (slot < 3'd4)) begin
        idx_nxt[slot[1:0]] = IDX_W'({beat_cnt, SB_W'(b)});
        slot = slot + 3'd1;
      end
    end
    num_nxt = full ? 3'd4 : sum[2:0];
`ifdef IDX_COLLECT_EARLY_DONE_EN
    ovf_nxt = 1'b0;
`else
    ovf_nxt = ovf_q | (sum > CNT_W'(4));
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = COLLECT;
      COLLECT: begin
`ifdef IDX_COLLECT_EARLY_DONE_EN
        if (accept && (last_beat || full)) state_nxt = DONE;
`else
        if (accept && last_beat) state_nxt = DONE;
`endif
      end
      DONE:    if (bus.i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt <= '0;
      num_q    <= '0;
      ovf_q    <= 1'b0;
      for (int j = 0; j < 4; j++) idx_q[j] <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
      num_q    <= '0;
      ovf_q    <= 1'b0;
      for (int j = 0; j < 4; j++) idx_q[j] <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + BC_W'(1);
      num_q    <= num_nxt;
      ovf_q    <= ovf_nxt;
      for (int j = 0; j < 4; j++) idx_q[j] <= idx_nxt[j];
    end
  end

  // Handshake outputs decode state only, never an input
  assign bus.o_flag_ready = (state == COLLECT);
  assign bus.o_res_valid  = (state == DONE);
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_idx1       = idx_q[0];
  assign bus.o_idx2       = idx_q[1];
  assign bus.o_idx3       = idx_q[2];
  assign bus.o_idx4       = idx_q[3];
  assign bus.o_num        = num_q;
  assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_idx_collect_ctrl.sv
// Directed and random frames for idx_collect_ctrl, checked against a set-bit list model.
// Honours IDX_COLLECT_EARLY_DONE_EN in the model when the macro is defined.
module tb_idx_collect_ctrl;
  localparam int SEG_W   = 8;
  localparam int NUM_SEG = 8;
  localparam int IDX_W   = 6;

  typedef logic [SEG_W-1:0] frame_t [NUM_SEG];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idx_collect_ctrl_if #(.SEG_W(SEG_W), .IDX_W(IDX_W)) bus ();

  idx_collect_ctrl #(.SEG_W(SEG_W), .NUM_SEG(NUM_SEG), .IDX_W(IDX_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int e_idx [4];
  int e_num, e_ovf, e_beats;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected result: ordered list of every set bit's global index, truncated to four
  task automatic model(input frame_t f);
    int q[$];
    e_beats = NUM_SEG;
    for (int k = 0; k < NUM_SEG; k++) begin
      for (int b = 0; b < SEG_W; b++)
        if (f[k][b]) q.push_back(k * SEG_W + b);
`ifdef IDX_COLLECT_EARLY_DONE_EN
      if (q.size() >= 4 && e_beats == NUM_SEG) e_beats = k + 1;
`endif
    end
    for (int j = 0; j < 4; j++) e_idx[j] = (j < q.size()) ? q[j] : 0;
    e_num = (q.size() > 4) ? 4 : q.size();
`ifdef IDX_COLLECT_EARLY_DONE_EN
    e_ovf = 0;
`else
    e_ovf = (q.size() > 4) ? 1 : 0;
`endif
  endtask

  task automatic check_result(input string tag);
    check({tag, ".idx1"}, 32'(bus.o_idx1), e_idx[0]);
    check({tag, ".idx2"}, 32'(bus.o_idx2), e_idx[1]);
    check({tag, ".idx3"}, 32'(bus.o_idx3), e_idx[2]);
    check({tag, ".idx4"}, 32'(bus.o_idx4), e_idx[3]);
    check({tag, ".num"},  32'(bus.o_num),  e_num);
    check({tag, ".ovf"},  32'(bus.o_overflow), e_ovf);
  endtask

  // gap_mode: 0 = continuous valid, 1 = toggle 1/0, 2 = random gaps
  task automatic run_frame(input frame_t f, input int gap_mode, input int hold, input string tag);
    int  k   = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    bit  v;
    model(f);
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check({tag, ".busy"}, 32'(bus.o_busy), 1);
    while (k < e_beats && cyc < 400) begin
      if (!bus.o_flag_ready) break;
      v   = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      bus.i_flag_valid = v;
      bus.i_flags      = v ? f[k] : SEG_W'($urandom);
      if (v) k++;
      @(negedge clk);
      cyc++;
    end
    bus.i_flag_valid = 1'b0;
    bus.i_flags      = '0;
    check({tag, ".beats"}, 32'(k), e_beats);
    check({tag, ".res_valid"}, 32'(bus.o_res_valid), 1);
    check({tag, ".flag_ready_done"}, 32'(bus.o_flag_ready), 0);
    check_result(tag);
    for (int h = 0; h < hold; h++) begin
      bus.i_start = h[0];
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(bus.o_res_valid), 1);
      check({tag, ".hold_ready"}, 32'(bus.o_flag_ready), 0);
      check({tag, ".hold_idx1"},  32'(bus.o_idx1), e_idx[0]);
      check({tag, ".hold_num"},   32'(bus.o_num), e_num);
    end
    bus.i_start     = (hold > 0);
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_start     = 1'b0;
    bus.i_res_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(bus.o_res_valid), 0);
    check({tag, ".post_busy"},  32'(bus.o_busy), 0);
    check({tag, ".post_num"},   32'(bus.o_num), e_num);
    check({tag, ".post_idx2"},  32'(bus.o_idx2), e_idx[1]);
  endtask

  initial begin
    frame_t f;
    int     d;
    bus.i_start      = 1'b0;
    bus.i_flag_valid = 1'b0;
    bus.i_flags      = '0;
    bus.i_res_ready  = 1'b0;

    #12;
    check("rst.busy",  32'(bus.o_busy), 0);
    check("rst.fr",    32'(bus.o_flag_ready), 0);
    check("rst.rv",    32'(bus.o_res_valid), 0);
    check("rst.num",   32'(bus.o_num), 0);
    check("rst.ovf",   32'(bus.o_overflow), 0);
    check("rst.idx1",  32'(bus.o_idx1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    f = '{default: '0}; f[1] = 8'h05;
    run_frame(f, 0, 0, "t1");

    f = '{default: '0}; f[0] = 8'h81; f[3] = 8'h12;
    run_frame(f, 0, 0, "t2");

    f = '{default: '0}; f[0] = 8'hFF;
    run_frame(f, 0, 0, "t3");

    f = '{default: '0};
    run_frame(f, 1, 0, "t4");

    f = '{default: '0}; f[2] = 8'h40; f[5] = 8'h09; f[7] = 8'h80;
    run_frame(f, 0, 5, "t5");

    // Abort mid-frame with two indices held
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_flag_valid = 1'b1;
      bus.i_flags      = (k == 0) ? 8'h06 : 8'h00;
      @(negedge clk);
    end
    bus.i_flag_valid = 1'b0;
    check("t6.pre_num", 32'(bus.o_num), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6.busy", 32'(bus.o_busy), 0);
    check("t6.fr",   32'(bus.o_flag_ready), 0);
    check("t6.rv",   32'(bus.o_res_valid), 0);
    check("t6.num",  32'(bus.o_num), 0);
    check("t6.idx1", 32'(bus.o_idx1), 0);
    check("t6.idx2", 32'(bus.o_idx2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    f = '{default: '0}; f[0] = 8'h81; f[3] = 8'h12;
    run_frame(f, 0, 0, "t6r");

    for (int n = 0; n < 24; n++) begin
      d = $urandom_range(2, 20);
      for (int k = 0; k < NUM_SEG; k++)
        for (int b = 0; b < SEG_W; b++)
          f[k][b] = ($urandom_range(0, d - 1) == 0);
      run_frame(f, 2, $urandom_range(0, 3), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
